// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter that shares one UART transmit stream
// between NREQ requesters, with an optional idle timeout that forces release.
module uart_tx_arb #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*8-1:0] req_tdata,
  input  logic [NREQ-1:0]   req_tvalid,
  input  logic [NREQ-1:0]   req_tlast,
  output logic [NREQ-1:0]   req_tready,
  output logic [7:0]        out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [NREQ-1:0]   grant,
  output logic              timeout_evt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] TO = TIMEOUT[CW-1:0];

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            evt_q, evt_d;

  logic [IW-1:0]   gidx;
  logic            g_valid, g_last, xfer;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register: everything here is control state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IW'(NREQ - 1);
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  // Next-state: round-robin pick in IDLE, lock/release bookkeeping in LOCK
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    evt_d    = 1'b0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(rr_q) + k) % NREQ);
      if (!pick_vld && req_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = LOCK;
          cnt_d             = '0;
        end
      end
      LOCK: begin
        if (xfer) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = gidx;
          end
        end else if (!g_valid) begin
          // Only requester silence counts; a busy UART holds the counter
          cnt_d = sat_inc(cnt_q);
          if (TIMEOUT != 0 && cnt_d == TO) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = gidx;
            evt_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output mux driven from the registered grant
  always_comb begin
    gidx      = '0;
    out_tdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        gidx      = IW'(i);
        out_tdata = req_tdata[i*8 +: 8];
      end
    end
    g_valid     = |(req_tvalid & grant_q);
    g_last      = |(req_tlast & grant_q);
    out_tvalid  = g_valid;
    req_tready  = grant_q & {NREQ{out_tready}};
    xfer        = g_valid & out_tready;
    grant       = grant_q;
    timeout_evt = evt_q;
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant_q) && $onehot0(req_tready));

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed packets per requester, a negedge
// monitor pops per-requester expected bytes on every accepted transfer.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_tdata;
  logic [1:0]  req_tvalid, req_tlast, req_tready, grant;
  logic [7:0]  out_tdata;
  logic        out_tvalid, out_tready, timeout_evt;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [8:0] xlog [$];

  uart_tx_arb #(.NREQ(2), .TIMEOUT(4), .CW(10)) dut (
    .clk(clk), .rst(rst), .req_tdata(req_tdata), .req_tvalid(req_tvalid),
    .req_tlast(req_tlast), .req_tready(req_tready), .out_tdata(out_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .grant(grant),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_g(input string nm, input logic [1:0] g);
    @(negedge clk);
    chk(nm, 32'(grant), 32'(g));
  endtask

  task automatic chk_ge(input string nm, input logic [1:0] g, input logic e);
    @(negedge clk);
    chk({nm, "_grant"}, 32'(grant), 32'(g));
    chk({nm, "_evt"}, 32'(timeout_evt), 32'(e));
  endtask

  task automatic send(input bit r, input logic [7:0] d, input logic last);
    int n;
    n = 0;
    req_tdata[{r, 3'b000} +: 8] = d;
    req_tlast[r]  = last;
    req_tvalid[r] = 1'b1;
    if (r) exp_q1.push_back(d);
    else   exp_q0.push_back(d);
    do begin
      @(negedge clk);
      n++;
    end while (!req_tready[r] && n < 200);
    if (!req_tready[r]) begin
      total++;
      bad++;
      $display("FAIL send_wait req%0d byte %0h: no ready after %0d cycles", r, d, n);
    end
    @(posedge clk); #1;
    req_tvalid[r] = 1'b0;
    req_tlast[r]  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst        = 1'b0;
    req_tvalid = '0;
    req_tlast  = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Monitor: one-hot rules every cycle, scoreboard pop on each transfer
  always @(negedge clk) begin
    if (rst) begin
      chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
      chk("ready_outside_grant", 32'(req_tready & ~grant), 32'd0);
      if (out_tvalid && out_tready) begin
        if (grant == 2'b01) begin
          xlog.push_back({1'b0, out_tdata});
          if (exp_q0.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req0 byte: got %0h, expected none", out_tdata);
          end else chk("data_req0", 32'(out_tdata), 32'(exp_q0.pop_front()));
        end else if (grant == 2'b10) begin
          xlog.push_back({1'b1, out_tdata});
          if (exp_q1.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req1 byte: got %0h, expected none", out_tdata);
          end else chk("data_req1", 32'(out_tdata), 32'(exp_q1.pop_front()));
        end else begin
          total++; bad++;
          $display("FAIL xfer_grant: got grant %0b, expected one-hot", grant);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] t3exp [4] = '{9'h151, 9'h152, 9'h153, 9'h0A0};
    rst        = 1'b0;
    req_tdata  = '0;
    req_tvalid = '0;
    req_tlast  = '0;
    out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_tdata", 32'(out_tdata), 32'd0);
    chk("rst_ready", 32'(req_tready), 32'd0);
    chk("rst_evt", 32'(timeout_evt), 32'd0);
    @(posedge clk); #1;

    // Single packet from req0
    fork
      begin send(1'b0, 8'h41, 1'b0); send(1'b0, 8'h42, 1'b0); send(1'b0, 8'h43, 1'b1); end
      begin
        chk_g("t1_arb", 2'b00); chk_g("t1_b0", 2'b01); chk_g("t1_b1", 2'b01);
        chk_g("t1_b2", 2'b01); chk_g("t1_rel", 2'b00);
      end
    join
    @(posedge clk); #1;

    // Contention after reset, then round robin
    do_reset();
    fork
      begin send(1'b0, 8'hA1, 1'b0); send(1'b0, 8'hA2, 1'b1); end
      begin send(1'b1, 8'hB1, 1'b0); send(1'b1, 8'hB2, 1'b1); end
      begin
        chk_g("t2_arb", 2'b00); chk_g("t2_r0a", 2'b01); chk_g("t2_r0b", 2'b01);
        chk_g("t2_idle", 2'b00); chk_g("t2_r1a", 2'b10); chk_g("t2_r1b", 2'b10);
        chk_g("t2_rel", 2'b00);
      end
    join
    @(posedge clk); #1;
    fork
      send(1'b0, 8'hA3, 1'b1);
      send(1'b1, 8'hB3, 1'b1);
      begin
        chk_g("t2c_arb", 2'b00); chk_g("t2c_r0", 2'b01); chk_g("t2c_idle", 2'b00);
        chk_g("t2c_r1", 2'b10); chk_g("t2c_rel", 2'b00);
      end
    join
    @(posedge clk); #1;

    // req1 locked mid-packet, req0 waiting, UART ready toggling
    xlog.delete();
    send(1'b1, 8'h51, 1'b0);
    fork
      begin send(1'b1, 8'h52, 1'b0); send(1'b1, 8'h53, 1'b1); end
      send(1'b0, 8'hA0, 1'b1);
      begin
        out_tready = 1'b1;
        @(posedge clk); #1 out_tready = 1'b0;
        @(posedge clk); #1 out_tready = 1'b0;
        @(posedge clk); #1 out_tready = 1'b1;
      end
    join
    @(posedge clk); #1;
    chk("t3_count", 32'(xlog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < xlog.size()) chk($sformatf("t3_order%0d", i), 32'(xlog[i]), 32'(t3exp[i]));

    // Idle timeout with req1 pending
    send(1'b0, 8'h61, 1'b0);
    fork
      send(1'b1, 8'h71, 1'b1);
      begin
        chk_ge("t4_idle1", 2'b01, 1'b0); chk_ge("t4_idle2", 2'b01, 1'b0);
        chk_ge("t4_idle3", 2'b01, 1'b0); chk_ge("t4_idle4", 2'b01, 1'b0);
        chk_ge("t4_rel", 2'b00, 1'b1); chk_ge("t4_r1", 2'b10, 1'b0);
      end
    join
    @(posedge clk); #1;

    // UART busy for 20 cycles: no timeout
    out_tready = 1'b0;
    fork
      send(1'b0, 8'h81, 1'b1);
      begin
        chk_g("t5_arb", 2'b00);
        repeat (20) chk_ge("t5_busy", 2'b01, 1'b0);
        @(posedge clk); #1 out_tready = 1'b1;
      end
    join
    @(posedge clk); #1;

    // Reset while req1 holds the lock with a byte pending
    out_tready         = 1'b0;
    req_tdata[15:8]    = 8'h91;
    req_tlast[1]       = 1'b1;
    req_tvalid[1]      = 1'b1;
    chk_g("t6_arb", 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    chk_g("t6_locked", 2'b10);
    @(posedge clk); #1 out_tready = 1'b1;
    @(negedge clk);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_tvalid", 32'(out_tvalid), 32'd0);
    chk("t6_tdata", 32'(out_tdata), 32'd0);
    chk("t6_ready", 32'(req_tready), 32'd0);
    @(posedge clk); #1;
    rst           = 1'b1;
    req_tdata[7:0] = 8'hB0;
    req_tlast[0]  = 1'b1;
    req_tvalid[0] = 1'b1;
    exp_q0.push_back(8'hB0);
    exp_q1.push_back(8'h91);
    chk_g("t6_rearb", 2'b00);
    @(posedge clk); #1;
    chk_g("t6_r0_first", 2'b01);
    @(posedge clk); #1 req_tvalid[0] = 1'b0;
    chk_g("t6_idle", 2'b00);
    @(posedge clk); #1;
    chk_g("t6_r1", 2'b10);
    @(posedge clk); #1 req_tvalid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter sharing one UART transmitter stream (tdata/tvalid/tready, stream-handshake style) between NREQ requesters, e.g. CPU port logic and a hardware debug monitor.
- Grants are packet-locked: the winner keeps the transmitter until it sends a byte flagged tlast, or until an idle timeout forces release.
- Sits between the requesters and the uart_tx instance, in the uart_tx clock domain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 1023, cycles a locked requester may hold tvalid low before forced release; 0 disables the timeout.
- CW, 10, width of the idle counter; TIMEOUT must be < 2^CW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- req_tdata  in  NREQ*8  byte from each requester; requester i uses bits [8i+7:8i].
- req_tvalid  in  NREQ  per-requester byte valid.
- req_tlast  in  NREQ  per-requester last byte of packet, sampled with its tdata.
- req_tready  out  NREQ  per-requester ready.
- out_tdata  out  8  byte to uart_tx input_axis_tdata.
- out_tvalid  out  1  to uart_tx input_axis_tvalid.
- out_tready  in  1  from uart_tx input_axis_tready.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- timeout_evt  out  1  one-cycle pulse when a forced release occurs.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, grant=0, rr_ptr=NREQ-1 (requester 0 has highest priority first), idle counter=0, timeout_evt=0.
  - While grant=0: out_tvalid=0, out_tdata=0, all req_tready=0.
  - Reset mid-packet drops the lock immediately with no flush; a byte already accepted by uart_tx still completes.
- Muxing:
  - Combinational from the registered grant.
  - out_tdata = req_tdata[g], out_tvalid = req_tvalid[g], req_tready[g] = out_tready.
  - req_tready of every non-granted requester = 0.
  - Transfer = out_tvalid & out_tready in a cycle.
- State IDLE:
  - When any req_tvalid=1, select the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register grant one-hot for that requester, go to LOCK, clear the idle counter.
  - Arbitration latency is 1 cycle: no byte transfers in the IDLE cycle.
- State LOCK:
  - Transfer with req_tlast[g]=1: next cycle grant=0, rr_ptr=g, state=IDLE.
  - Transfer without tlast: stay in LOCK, clear the idle counter.
  - req_tvalid[g]=0: increment the idle counter, saturating.
  - req_tvalid[g]=1 and out_tready=0: the UART is busy, not the requester; hold the counter.
  - TIMEOUT!=0 and the counter reaches TIMEOUT: next cycle grant=0, rr_ptr=g, state=IDLE, timeout_evt=1 for one cycle.
- Simultaneous events:
  - tlast transfer and timeout in the same cycle cannot coincide, because a transfer clears the counter.
  - A new request arriving in the release cycle is arbitrated in the following IDLE cycle.
- Rule: at most one bit of grant and of req_tready set in any cycle. Any violation is an error.
- Re-arbitration order: a requester that just released is the lowest priority for the next grant.

Test Plan:
- Reset, then req0 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43), out_tready=1.
  - Required: grant=01 one cycle after tvalid.
  - Required: out_tdata 0x41..0x43 on consecutive cycles, then grant=00.
- req0 and req1 assert tvalid in the same cycle after reset.
  - Required: req0 is served first; req1 is granted the cycle after req0's tlast+1.
  - Required: a third contention grants req0 again (round robin).
- req1 locked mid-packet while req0 requests; out_tready toggles 1,0,0,1.
  - Required: req0 receives no req_tready until req1's tlast.
  - Required: req1's bytes are delivered in order, none duplicated.
- TIMEOUT=4: req0 sends one byte without tlast, then drops tvalid.
  - Required: after 4 idle cycles, timeout_evt pulses once and grant=00.
  - Required: a pending req1 is granted on the next cycle.
- out_tready=0 for 20 cycles with req0 valid and TIMEOUT=4.
  - Required: no timeout; grant stays 01.
- rst=0 asserted while req1 is locked with a byte pending.
  - Required: next cycle grant=00, out_tvalid=0, all req_tready=0.
  - Required: after release, req0 wins first.
